// File: rtl/csr_unit_pkg.sv
// Shared constants and types for the machine-mode CSR unit: CSR addresses,
// funct3 encodings, cause codes, mstatus layout and the CSR read-modify-write helpers.
package csr_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [2:0] FUNCT_CSRRW  = 3'b001;
    localparam logic [2:0] FUNCT_CSRRS  = 3'b010;
    localparam logic [2:0] FUNCT_CSRRC  = 3'b011;
    localparam logic [2:0] FUNCT_CSRRWI = 3'b101;
    localparam logic [2:0] FUNCT_CSRRSI = 3'b110;
    localparam logic [2:0] FUNCT_CSRRCI = 3'b111;

    localparam logic [3:0] EXCEPT_INSTR_MISALIGNED    = 4'd0;
    localparam logic [3:0] EXCEPT_ILLEGAL_INSTRUCTION = 4'd2;
    localparam logic [3:0] EXCEPT_BREAKPOINT          = 4'd3;
    localparam logic [3:0] EXCEPT_ECALL_M             = 4'd11;

    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    localparam logic [31:0] MIE_MASK      = 32'h0000_0888;
    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

    typedef enum logic [2:0] {
        OP_RW  = FUNCT_CSRRW,
        OP_RS  = FUNCT_CSRRS,
        OP_RC  = FUNCT_CSRRC,
        OP_RWI = FUNCT_CSRRWI,
        OP_RSI = FUNCT_CSRRSI,
        OP_RCI = FUNCT_CSRRCI
    } csr_op_t;

    typedef struct packed {
        logic [18:0] rsv_hi;
        logic [1:0]  mpp;
        logic [2:0]  rsv_mid;
        logic        mpie;
        logic [2:0]  rsv_lo2;
        logic        mie;
        logic [2:0]  rsv_lo;
    } mstatus_t;

    typedef struct packed {
        logic       intr;
        logic [3:0] code;
    } trap_code_t;

    // Set/clear forms with a zero source are pure reads.
    function automatic logic csr_writes(input logic [2:0] op, input logic zero);
        case (csr_op_t'(op))
            OP_RW, OP_RWI:                csr_writes = 1'b1;
            OP_RS, OP_RSI, OP_RC, OP_RCI: csr_writes = !zero;
            default:                      csr_writes = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] csr_apply(input logic [2:0] op, input logic [31:0] old,
                                              input logic [31:0] wdata);
        case (csr_op_t'(op))
            OP_RW, OP_RWI: csr_apply = wdata;
            OP_RS, OP_RSI: csr_apply = old | wdata;
            OP_RC, OP_RCI: csr_apply = old & ~wdata;
            default:       csr_apply = old;
        endcase
    endfunction

endpackage

// File: rtl/csr_unit_counter.sv
// 64-bit event counter with independently writable halves; a half-write
// takes precedence over the increment for that half in the same cycle.
module csr_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc,
    input  logic        lo_we,
    input  logic        hi_we,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [63:0] sum;

    assign sum = value + {63'b0, inc};

    always_ff @(posedge clock) begin
        if (!reset) begin
            value <= '0;
        end else begin
            value[31:0] <= lo_we ? wdata : sum[31:0];
            // A low-half write cancels the carry the increment would have produced.
            if (hi_we)
                value[63:32] <= wdata;
            else if (!lo_we)
                value[63:32] <= sum[63:32];
        end
    end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap controller (exceptions, interrupts, mret, wfi).
// Define CSR_COUNTERS_EN to build the 64-bit mcycle/minstret counters and their shadows.
//
// state  | meaning
// RUN    | normal execution, interrupts sampled on commit
// WFI    | pipeline held until an enabled interrupt is pending
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL    = 32'h4000_1100,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        csr_valid,
    input  logic [2:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        csr_zero,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_tval,
    input  logic [31:0] exc_pc,
    input  logic [31:0] next_pc,
    input  logic        commit,
    input  logic        mret_valid,
    input  logic        wfi_valid,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic        soft_irq,
    output logic        trap_valid,
    output logic [31:0] trap_pc,
    output logic        wfi_stall
);

    typedef enum logic {ST_RUN, ST_WFI} state_t;

    state_t      state, state_next;
    mstatus_t    mstatus_q, ms_trap, ms_mret, ms_wr;
    logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic        msip_q, mtip_q, meip_q;
    logic [31:0] mip_val, pend;
    logic [31:0] rd, csr_new;
    logic [63:0] cyc_val, ins_val;
    logic        known, does_write, csr_we;
    logic        irq_take, trap_take, mret_take;
    logic [3:0]  irq_code;
    trap_code_t  tc;
    logic [31:0] vec_off;

    assign mip_val = {20'b0, meip_q, 3'b0, mtip_q, 3'b0, msip_q, 3'b0};
    assign pend    = mip_val & mie_q;

    always_comb begin
        irq_code = IRQ_MTI;
        if (pend[11])
            irq_code = IRQ_MEI;
        else if (pend[3])
            irq_code = IRQ_MSI;
    end

    assign irq_take  = mstatus_q.mie && (pend != '0) && (commit || state == ST_WFI);
    assign trap_take = exc_valid || irq_take;
    assign mret_take = mret_valid && !trap_take;

    assign tc      = exc_valid ? trap_code_t'({1'b0, exc_cause}) : trap_code_t'({1'b1, irq_code});
    assign vec_off = (mtvec_q[0] && tc.intr) ? {26'b0, tc.code, 2'b00} : 32'h0;

    assign trap_valid = trap_take || mret_take;
    assign trap_pc    = trap_take ? ((mtvec_q & ~32'h3) + vec_off) : mepc_q;
    assign wfi_stall  = (state == ST_WFI);

`ifdef CSR_COUNTERS_EN
    logic cyc_lo_we, cyc_hi_we, ins_lo_we, ins_hi_we;

    assign cyc_lo_we = csr_we && (csr_addr == CSR_MCYCLE);
    assign cyc_hi_we = csr_we && (csr_addr == CSR_MCYCLEH);
    assign ins_lo_we = csr_we && (csr_addr == CSR_MINSTRET);
    assign ins_hi_we = csr_we && (csr_addr == CSR_MINSTRETH);

    csr_counter u_mcycle (
        .clock (clock),
        .reset (reset),
        .inc   (1'b1),
        .lo_we (cyc_lo_we),
        .hi_we (cyc_hi_we),
        .wdata (csr_new),
        .value (cyc_val)
    );

    csr_counter u_minstret (
        .clock (clock),
        .reset (reset),
        .inc   (commit),
        .lo_we (ins_lo_we),
        .hi_we (ins_hi_we),
        .wdata (csr_new),
        .value (ins_val)
    );
`else
    assign cyc_val = '0;
    assign ins_val = '0;
`endif

    always_comb begin
        rd    = '0;
        known = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:                  rd = mstatus_q;
            CSR_MISA:                     rd = MISA_VAL;
            CSR_MIE:                      rd = mie_q;
            CSR_MTVEC:                    rd = mtvec_q;
            CSR_MSCRATCH:                 rd = mscratch_q;
            CSR_MEPC:                     rd = mepc_q;
            CSR_MCAUSE:                   rd = mcause_q;
            CSR_MTVAL:                    rd = mtval_q;
            CSR_MIP:                      rd = mip_val;
            CSR_MCYCLE, CSR_CYCLE:        rd = cyc_val[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:      rd = cyc_val[63:32];
            CSR_MINSTRET, CSR_INSTRET:    rd = ins_val[31:0];
            CSR_MINSTRETH, CSR_INSTRETH:  rd = ins_val[63:32];
            CSR_MVENDORID, CSR_MARCHID,
            CSR_MIMPID:                   rd = '0;
            CSR_MHARTID:                  rd = HART_ID;
            default:                      known = 1'b0;
        endcase
    end

    assign csr_rdata   = rd;
    assign does_write  = csr_writes(csr_op, csr_zero);
    assign csr_illegal = csr_valid && (!known || (csr_addr[11:10] == 2'b11 && does_write));
    assign csr_new     = csr_apply(csr_op, rd, csr_wdata);
    assign csr_we      = csr_valid && !csr_illegal && does_write && !trap_take && !mret_valid;

    always_comb begin
        ms_trap      = mstatus_q;
        ms_trap.mpie = mstatus_q.mie;
        ms_trap.mie  = 1'b0;
        ms_mret      = mstatus_q;
        ms_mret.mie  = mstatus_q.mpie;
        ms_mret.mpie = 1'b1;
        ms_wr        = mstatus_t'(MSTATUS_RESET);
        ms_wr.mie    = csr_new[3];
        ms_wr.mpie   = csr_new[7];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mstatus_q  <= mstatus_t'(MSTATUS_RESET);
            mie_q      <= '0;
            mtvec_q    <= RESET_MTVEC;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            meip_q     <= 1'b0;
        end else begin
            msip_q <= soft_irq;
            mtip_q <= timer_irq;
            meip_q <= ext_irq;
            if (trap_take) begin
                mstatus_q <= ms_trap;
                mepc_q    <= exc_valid ? exc_pc : next_pc;
                mcause_q  <= {tc.intr, 27'b0, tc.code};
                mtval_q   <= exc_valid ? exc_tval : 32'h0;
            end else if (mret_take) begin
                mstatus_q <= ms_mret;
            end else if (csr_we) begin
                case (csr_addr)
                    CSR_MSTATUS:  mstatus_q  <= ms_wr;
                    CSR_MIE:      mie_q      <= csr_new & MIE_MASK;
                    CSR_MTVEC:    mtvec_q    <= csr_new & ~32'h2;
                    CSR_MSCRATCH: mscratch_q <= csr_new;
                    CSR_MEPC:     mepc_q     <= csr_new & ~32'h3;
                    CSR_MCAUSE:   mcause_q   <= csr_new;
                    CSR_MTVAL:    mtval_q    <= csr_new;
                    default:      ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)
            state <= ST_RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: if (wfi_valid && pend == '0 && !trap_take) state_next = ST_WFI;
            ST_WFI: if (pend != '0) state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

endmodule

// File: tb/tb_csr_unit.sv
// Directed, self-checking bench for csr_unit: a CSR access vector table
// followed by hand-written trap, mret, wfi, counter and reset sequences.
module tb_csr_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        csr_valid;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_zero;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_tval, exc_pc, next_pc;
    logic        commit, mret_valid, wfi_valid;
    logic        ext_irq, timer_irq, soft_irq;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic        wfi_stall;

    int total = 0;
    int bad   = 0;

    csr_unit dut (
        .clock(clock), .reset(reset),
        .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_zero(csr_zero),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
        .exc_pc(exc_pc), .next_pc(next_pc), .commit(commit),
        .mret_valid(mret_valid), .wfi_valid(wfi_valid),
        .ext_irq(ext_irq), .timer_irq(timer_irq), .soft_irq(soft_irq),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .wfi_stall(wfi_stall)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        zero;
        logic [31:0] rdata;
        logic        ill;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic csr_set(input logic [2:0] op, input logic [11:0] addr,
                           input logic [31:0] wdata, input logic zero);
        csr_valid = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wdata;
        csr_zero  = zero;
    endtask

    task automatic rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
        csr_set(3'b010, addr, 32'h0, 1'b1);
        #1;
        chk(name, csr_rdata, exp);
    endtask

    initial begin
        vecs[0]  = '{3'b001, 12'h340, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0};
        vecs[1]  = '{3'b010, 12'h340, 32'h00000000, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{3'b010, 12'h340, 32'h0000FFFF, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{3'b011, 12'h340, 32'hFF000000, 1'b0, 32'hDEADFFFF, 1'b0};
        vecs[4]  = '{3'b111, 12'h340, 32'h00000000, 1'b1, 32'h00ADFFFF, 1'b0};
        vecs[5]  = '{3'b001, 12'h340, 32'h12345678, 1'b0, 32'h00ADFFFF, 1'b0};
        vecs[6]  = '{3'b010, 12'h340, 32'h00000000, 1'b1, 32'h12345678, 1'b0};
        vecs[7]  = '{3'b001, 12'hF14, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        vecs[8]  = '{3'b010, 12'hF14, 32'h00000000, 1'b1, 32'h00000000, 1'b0};
        vecs[9]  = '{3'b010, 12'h7FF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        vecs[10] = '{3'b101, 12'h305, 32'h00001003, 1'b0, 32'h00000000, 1'b0};
        vecs[11] = '{3'b010, 12'h305, 32'h00000000, 1'b1, 32'h00001001, 1'b0};
        vecs[12] = '{3'b001, 12'h341, 32'h00000203, 1'b0, 32'h00000000, 1'b0};
        vecs[13] = '{3'b010, 12'h341, 32'h00000000, 1'b1, 32'h00000200, 1'b0};
        vecs[14] = '{3'b001, 12'h300, 32'hFFFFFFFF, 1'b0, 32'h00001800, 1'b0};
        vecs[15] = '{3'b010, 12'h300, 32'h00000000, 1'b1, 32'h00001888, 1'b0};
        vecs[16] = '{3'b001, 12'h300, 32'h00000000, 1'b0, 32'h00001888, 1'b0};
        vecs[17] = '{3'b010, 12'h300, 32'h00000000, 1'b1, 32'h00001800, 1'b0};
        vecs[18] = '{3'b001, 12'h304, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0};
        vecs[19] = '{3'b001, 12'h304, 32'h00000000, 1'b0, 32'h00000888, 1'b0};
        vecs[20] = '{3'b001, 12'h344, 32'h0000FFFF, 1'b0, 32'h00000000, 1'b0};
        vecs[21] = '{3'b010, 12'h344, 32'h00000000, 1'b1, 32'h00000000, 1'b0};
        vecs[22] = '{3'b010, 12'h301, 32'h00000000, 1'b1, 32'h40001100, 1'b0};
        vecs[23] = '{3'b110, 12'h304, 32'h00000000, 1'b1, 32'h00000000, 1'b0};

        reset = 1'b0;
        csr_valid = 0; csr_op = 3'b010; csr_addr = '0; csr_wdata = '0; csr_zero = 1'b1;
        exc_valid = 0; exc_cause = '0; exc_tval = '0; exc_pc = '0; next_pc = '0;
        commit = 0; mret_valid = 0; wfi_valid = 0;
        ext_irq = 0; timer_irq = 0; soft_irq = 0;
        tick();
        tick();
        chk("reset_trap_valid", {31'b0, trap_valid}, 32'h0);
        chk("reset_wfi_stall", {31'b0, wfi_stall}, 32'h0);
        chk("reset_illegal", {31'b0, csr_illegal}, 32'h0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            csr_set(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].zero);
            #1;
            chk($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].rdata);
            chk($sformatf("vec%0d_illegal", i), {31'b0, csr_illegal}, {31'b0, vecs[i].ill});
            tick();
        end
        csr_valid = 0;

        // Vectored timer interrupt: mtvec=0x1001.
        csr_set(3'b001, 12'h304, 32'h80, 1'b0); tick();
        csr_set(3'b001, 12'h300, 32'h8, 1'b0);  tick();
        csr_valid = 0;
        timer_irq = 1;
        tick();
        commit = 1; next_pc = 32'h444;
        #1;
        chk("irq_trap_valid", {31'b0, trap_valid}, 32'h1);
        chk("irq_trap_pc", trap_pc, 32'h101C);
        tick();
        commit = 0; timer_irq = 0;
        rd_chk("irq_mcause", 12'h342, 32'h80000007);
        rd_chk("irq_mepc", 12'h341, 32'h444);
        rd_chk("irq_mtval", 12'h343, 32'h0);
        rd_chk("irq_mstatus", 12'h300, 32'h1880);
        csr_valid = 0;
        tick();
        mret_valid = 1;
        #1;
        chk("mret1_valid", {31'b0, trap_valid}, 32'h1);
        chk("mret1_pc", trap_pc, 32'h444);
        tick();
        mret_valid = 0;
        rd_chk("mret1_mstatus", 12'h300, 32'h1888);

        // Exception beats a pending external interrupt and drops a same-cycle CSR write.
        csr_set(3'b001, 12'h304, 32'h800, 1'b0); tick();
        csr_valid = 0;
        ext_irq = 1;
        tick();
        exc_valid = 1; exc_cause = 4'd2; exc_pc = 32'h200; exc_tval = 32'hBAD; commit = 1;
        csr_set(3'b001, 12'h340, 32'h55, 1'b0);
        #1;
        chk("exc_trap_valid", {31'b0, trap_valid}, 32'h1);
        chk("exc_trap_pc", trap_pc, 32'h1000);
        tick();
        exc_valid = 0; csr_valid = 0;
        #1;
        chk("irq_waits", {31'b0, trap_valid}, 32'h0);
        commit = 0;
        rd_chk("exc_mcause", 12'h342, 32'h2);
        rd_chk("exc_mepc", 12'h341, 32'h200);
        rd_chk("exc_mtval", 12'h343, 32'hBAD);
        rd_chk("exc_mstatus", 12'h300, 32'h1880);
        rd_chk("exc_drops_write", 12'h340, 32'h12345678);
        csr_valid = 0;
        mret_valid = 1;
        #1;
        chk("mret2_valid", {31'b0, trap_valid}, 32'h1);
        chk("mret2_pc", trap_pc, 32'h200);
        tick();
        mret_valid = 0;
        rd_chk("mret2_mstatus", 12'h300, 32'h1888);
        csr_valid = 0;
        commit = 1; next_pc = 32'h300;
        #1;
        chk("mei_trap_valid", {31'b0, trap_valid}, 32'h1);
        chk("mei_trap_pc", trap_pc, 32'h102C);
        tick();
        commit = 0; ext_irq = 0;
        rd_chk("mei_mcause", 12'h342, 32'h8000000B);
        rd_chk("mei_mepc", 12'h341, 32'h300);
        csr_valid = 0;
        tick();

        // WFI with MIE=0, MEIE=1: wake on ext_irq without trapping.
        wfi_valid = 1; commit = 1;
        #1;
        chk("wfi_enter_stall0", {31'b0, wfi_stall}, 32'h0);
        tick();
        wfi_valid = 0; commit = 0;
        chk("wfi_stall1", {31'b0, wfi_stall}, 32'h1);
        tick();
        tick();
        chk("wfi_stall_hold", {31'b0, wfi_stall}, 32'h1);
        ext_irq = 1;
        tick();
        chk("wfi_wake_no_trap", {31'b0, trap_valid}, 32'h0);
        tick();
        chk("wfi_wake_run", {31'b0, wfi_stall}, 32'h0);
        rd_chk("wfi_mstatus", 12'h300, 32'h1880);
        csr_valid = 0;
        wfi_valid = 1; commit = 1;
        tick();
        wfi_valid = 0; commit = 0;
        chk("wfi_pending_nop", {31'b0, wfi_stall}, 32'h0);
        ext_irq = 0;
        tick();

`ifdef CSR_COUNTERS_EN
        csr_set(3'b001, 12'hB00, 32'hFFFFFFFF, 1'b0);
        tick();
        csr_valid = 0;
        tick();
        tick();
        rd_chk("mcycleh_carry", 12'hB80, 32'h1);
        rd_chk("mcycle_wrap", 12'hB00, 32'h1);
        rd_chk("cycleh_shadow", 12'hC80, 32'h1);
        csr_set(3'b001, 12'hB02, 32'h5, 1'b0);
        commit = 1;
        tick();
        csr_valid = 0;
        tick();
        commit = 0;
        rd_chk("minstret_count", 12'hB02, 32'h6);
        rd_chk("instret_shadow", 12'hC02, 32'h6);
        rd_chk("minstreth", 12'hB82, 32'h0);
`else
        rd_chk("mcycle_off_zero", 12'hB00, 32'h0);
        chk("mcycle_off_legal", {31'b0, csr_illegal}, 32'h0);
        csr_set(3'b001, 12'hB00, 32'h1, 1'b0);
        #1;
        chk("mcycle_off_wr_legal", {31'b0, csr_illegal}, 32'h0);
        tick();
        rd_chk("mcycle_off_wr_ignored", 12'hB00, 32'h0);
`endif
        csr_set(3'b001, 12'hC00, 32'h0, 1'b0);
        #1;
        chk("cycle_shadow_wr_illegal", {31'b0, csr_illegal}, 32'h1);
        csr_valid = 0;
        tick();

        // Reset while in WFI.
        wfi_valid = 1;
        tick();
        wfi_valid = 0;
        chk("wfi_before_reset", {31'b0, wfi_stall}, 32'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("reset_from_wfi", {31'b0, wfi_stall}, 32'h0);
        rd_chk("reset_mtvec", 12'h305, 32'h0);
        rd_chk("reset_mstatus", 12'h300, 32'h1800);
        rd_chk("reset_mscratch", 12'h340, 32'h0);
        csr_valid = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
